// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/execute/memory status in, pipeline register enables/flushes out.
// HAZARD_PERF_CNT_EN adds the stallCycles_o counter output.
interface pipeline_hazard_ctrl_if #(
    parameter int REGISTER_ADDRESS_WIDTH = 5
);
    logic [REGISTER_ADDRESS_WIDTH-1:0] rs1D_i;
    logic [REGISTER_ADDRESS_WIDTH-1:0] rs2D_i;
    logic [REGISTER_ADDRESS_WIDTH-1:0] AD3E_i;
    logic                              resultSRCE_i;
    logic                              regWriteE_i;
    logic                              branchTakenE_i;
    logic                              memReqM_i;
    logic                              memReadyM_i;
    logic                              enF_o;
    logic                              enD_o;
    logic                              enE_o;
    logic                              enM_o;
    logic                              flushD_o;
    logic                              flushE_o;
    logic                              memErr_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0]                       stallCycles_o;

    modport master (
        output rs1D_i, rs2D_i, AD3E_i, resultSRCE_i, regWriteE_i,
               branchTakenE_i, memReqM_i, memReadyM_i,
        input  enF_o, enD_o, enE_o, enM_o, flushD_o, flushE_o, memErr_o,
               stallCycles_o
    );
    modport slave (
        input  rs1D_i, rs2D_i, AD3E_i, resultSRCE_i, regWriteE_i,
               branchTakenE_i, memReqM_i, memReadyM_i,
        output enF_o, enD_o, enE_o, enM_o, flushD_o, flushE_o, memErr_o,
               stallCycles_o
    );
`else
    modport master (
        output rs1D_i, rs2D_i, AD3E_i, resultSRCE_i, regWriteE_i,
               branchTakenE_i, memReqM_i, memReadyM_i,
        input  enF_o, enD_o, enE_o, enM_o, flushD_o, flushE_o, memErr_o
    );
    modport slave (
        input  rs1D_i, rs2D_i, AD3E_i, resultSRCE_i, regWriteE_i,
               branchTakenE_i, memReqM_i, memReadyM_i,
        output enF_o, enD_o, enE_o, enM_o, flushD_o, flushE_o, memErr_o
    );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard/stall controller: load-use interlock, branch flush, memory wait with timeout.
// Optional HAZARD_PERF_CNT_EN adds a saturating 16-bit stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int MEM_TIMEOUT            = 15
) (
    input logic                   clk,
    input logic                   rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TIMEOUT_CNT = WCW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

    state_t                            state;
    logic [WCW-1:0]                    wait_cnt;
    logic [REGISTER_ADDRESS_WIDTH-1:0] rs1, rs2, ad3;
    logic                              load_use, mem_stall, freeze;

    assign rs1 = hz.rs1D_i;
    assign rs2 = hz.rs2D_i;
    assign ad3 = hz.AD3E_i;

    assign load_use  = hz.resultSRCE_i & hz.regWriteE_i & (ad3 != '0) &
                       ((ad3 == rs1) | (ad3 == rs2));
    assign mem_stall = hz.memReqM_i & ~hz.memReadyM_i;
    // A dropped request counts as ready, so in RUN and MEMWAIT alike only a live stall freezes.
    assign freeze    = (state == ERR) | mem_stall;

    always_comb begin
        hz.enF_o    = 1'b1;
        hz.enD_o    = 1'b1;
        hz.enE_o    = 1'b1;
        hz.enM_o    = 1'b1;
        hz.flushD_o = 1'b0;
        hz.flushE_o = 1'b0;
        if (!rst_n) begin
            hz.enF_o    = 1'b0;
            hz.enD_o    = 1'b0;
            hz.enE_o    = 1'b0;
            hz.enM_o    = 1'b0;
            hz.flushD_o = 1'b1;
            hz.flushE_o = 1'b1;
        end else if (freeze) begin
            hz.enF_o = 1'b0;
            hz.enD_o = 1'b0;
            hz.enE_o = 1'b0;
            hz.enM_o = 1'b0;
        end else if (hz.branchTakenE_i) begin
            // Branch wins over load-use: the dependent instruction is squashed anyway.
            hz.flushD_o = 1'b1;
            hz.flushE_o = 1'b1;
        end else if (load_use) begin
            hz.enF_o    = 1'b0;
            hz.enD_o    = 1'b0;
            hz.flushE_o = 1'b1;
        end
    end

    assign hz.memErr_o = (state == ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: if (mem_stall) begin
                    state    <= MEMWAIT;
                    wait_cnt <= WCW'(1);
                end
                MEMWAIT: if (!mem_stall) begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    state <= ERR;
                end else begin
                    wait_cnt <= wait_cnt + WCW'(1);
                end
                default: state <= ERR;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (!hz.enF_o && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign hz.stallCycles_o = stall_cnt;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4): directed vector table, async-reset sequence,
// randomized run against a streak-counting reference model; perf counter checks with HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;
    localparam int AW = 5;
    localparam int TO = 4;

    localparam logic [6:0] O_RST = 7'b0000_110;
    localparam logic [6:0] O_RUN = 7'b1111_000;
    localparam logic [6:0] O_BR  = 7'b1111_110;
    localparam logic [6:0] O_LU  = 7'b0011_010;
    localparam logic [6:0] O_FRZ = 7'b0000_000;
    localparam logic [6:0] O_ERR = 7'b0000_001;

    typedef struct {
        logic          rst;
        logic [AW-1:0] rs1, rs2, ad3;
        logic          ld, rw, br, req, rdy;
        logic [6:0]    exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nbad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REGISTER_ADDRESS_WIDTH(AW)) hz();

    pipeline_hazard_ctrl #(.REGISTER_ADDRESS_WIDTH(AW), .MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    function automatic vec_t mk(input logic r, input logic [AW-1:0] a, b, c,
                                input logic ld, rw, br, rq, rd, input logic [6:0] e);
        vec_t v;
        v.rst = r; v.rs1 = a; v.rs2 = b; v.ad3 = c;
        v.ld = ld; v.rw = rw; v.br = br; v.req = rq; v.rdy = rd; v.exp = e;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {hz.enF_o, hz.enD_o, hz.enE_o, hz.enM_o, hz.flushD_o, hz.flushE_o, hz.memErr_o};
    endfunction

    task automatic drive(input vec_t v);
        rst_n             = v.rst;
        hz.rs1D_i         = v.rs1;
        hz.rs2D_i         = v.rs2;
        hz.AD3E_i         = v.ad3;
        hz.resultSRCE_i   = v.ld;
        hz.regWriteE_i    = v.rw;
        hz.branchTakenE_i = v.br;
        hz.memReqM_i      = v.req;
        hz.memReadyM_i    = v.rdy;
    endtask

    task automatic chk(input string nm, input logic [6:0] exp);
        logic [6:0] got;
        got = outs();
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got {enFDEM,flD,flE,err}=%b expected %b", nm, got, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One cycle: inputs change shortly after the rising edge, outputs sampled on the falling edge.
    task automatic cycle(input vec_t v, input string nm);
        @(posedge clk);
        #2;
        drive(v);
        @(negedge clk);
        chk(nm, v.exp);
    endtask

    // Reference model: counts consecutive not-ready memory cycles; error once the streak exceeds MEM_TIMEOUT.
    int          m_streak;
    bit          m_err;
    logic [15:0] m_perf;

    function automatic logic [6:0] model_out(input vec_t v);
        bit lu, stall;
        if (!v.rst) return O_RST;
        stall = v.req && !v.rdy;
        lu = v.ld && v.rw && (v.ad3 != 0) && (v.ad3 == v.rs1 || v.ad3 == v.rs2);
        if (m_err)  return O_ERR;
        if (stall)  return O_FRZ;
        if (v.br)   return O_BR;
        if (lu)     return O_LU;
        return O_RUN;
    endfunction

    task automatic model_step(input vec_t v, input logic [6:0] e);
        if (!v.rst) begin
            m_streak = 0; m_err = 0; m_perf = 0;
        end else begin
            if (!e[6] && m_perf != 16'hFFFF) m_perf = m_perf + 16'd1;
            if (!m_err) begin
                if (v.req && !v.rdy) begin
                    m_streak++;
                    if (m_streak == TO + 1) m_err = 1;
                end else begin
                    m_streak = 0;
                end
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        int drought;

        // rst rs1 rs2 ad3 ld rw br req rdy exp
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
        tbl.push_back(mk(1, 1, 5, 5, 1, 1, 0, 0, 0, O_LU));
        tbl.push_back(mk(1, 1, 2, 3, 0, 0, 0, 0, 0, O_RUN));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, O_RUN));
        tbl.push_back(mk(1, 1, 5, 5, 1, 1, 1, 0, 0, O_BR));
        tbl.push_back(mk(1, 5, 0, 5, 1, 0, 0, 0, 0, O_RUN));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, O_RUN));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
        tbl.push_back(mk(1, 5, 1, 5, 1, 1, 0, 1, 1, O_LU));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, O_BR));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_ERR));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 1, O_ERR));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_RST));
        for (int i = 0; i < TO + 1; i++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_ERR));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));

        drive(tbl[0]);
        foreach (tbl[i]) cycle(tbl[i], $sformatf("vec%0d", i));

        // Async clear of memErr_o in the middle of a cycle while in ERR.
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST), "pre_err_rst");
        for (int i = 0; i < TO + 1; i++)
            cycle(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ), "to_stall");
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_ERR), "in_err");
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_err_clear", O_RST);

`ifdef HAZARD_PERF_CNT_EN
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST), "perf_rst");
        chk16("perf_reset", hz.stallCycles_o, 16'd0);
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN), "perf_run");
        cycle(mk(1, 1, 5, 5, 1, 1, 0, 0, 0, O_LU), "perf_lu");
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN), "perf_run2");
        for (int i = 0; i < 3; i++)
            cycle(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ), "perf_mw");
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, O_RUN), "perf_rdy");
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN), "perf_idle");
        chk16("perf_count4", hz.stallCycles_o, 16'd4);
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            #2;
            drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
        end
        @(negedge clk);
        chk("perf_sat_err", O_ERR);
        chk16("perf_saturate", hz.stallCycles_o, 16'hFFFF);
`endif

        // Randomized run against the reference model.
        m_streak = 0; m_err = 0; m_perf = 0;
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST), "rnd_rst");
        drought = 0;
        for (int n = 0; n < 3000; n++) begin
            v.rst = ($urandom_range(59) != 0);
            v.rs1 = AW'($urandom_range(3));
            v.rs2 = AW'($urandom_range(3));
            v.ad3 = AW'($urandom_range(3));
            v.ld  = 1'($urandom_range(1));
            v.rw  = 1'($urandom_range(1));
            v.br  = ($urandom_range(4) == 0);
            v.req = 1'($urandom_range(1));
            if (drought == 0 && $urandom_range(49) == 0) drought = 6;
            if (drought > 0) begin
                v.req = 1'b1;
                v.rdy = 1'b0;
                drought--;
            end else begin
                v.rdy = ($urandom_range(3) != 0);
            end
            v.exp = model_out(v);
            cycle(v, $sformatf("rnd%0d", n));
`ifdef HAZARD_PERF_CNT_EN
            chk16($sformatf("rnd_perf%0d", n), hz.stallCycles_o, m_perf);
`endif
            model_step(v, v.exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the five-stage RISC-V pipeline. It drives the enable and flush inputs of the fetch, decode, execute and memory pipeline registers. It resolves three conditions:
- load-use interlocks, by stalling fetch/decode for one cycle and inserting a bubble into execute;
- taken branches and jumps, by flushing decode and execute;
- multi-cycle data-memory accesses, by freezing the whole pipeline until memory is ready, with a timeout to a sticky error state.

## Interface
Parameters:
- REGISTER_ADDRESS_WIDTH, 5, register index width
- MEM_TIMEOUT, 15, maximum consecutive not-ready memory cycles before error (≥1)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- rs1D_i  in  REGISTER_ADDRESS_WIDTH  source register 1 of instruction in decode
- rs2D_i  in  REGISTER_ADDRESS_WIDTH  source register 2 of instruction in decode
- AD3E_i  in  REGISTER_ADDRESS_WIDTH  destination register of instruction in execute
- resultSRCE_i  in  1  execute instruction is a load
- regWriteE_i  in  1  execute instruction writes the register file
- branchTakenE_i  in  1  execute resolved a taken branch or jump
- memReqM_i  in  1  memory-stage instruction accesses data memory
- memReadyM_i  in  1  data memory completes the access this cycle
- enF_o, enD_o, enE_o, enM_o  out  1 each  pipeline register enables
- flushD_o, flushE_o  out  1 each  load bubble (all control zero) into decode/execute register
- memErr_o  out  1  sticky memory timeout error
- stallCycles_o  out  16  stall counter (only with HAZARD_PERF_CNT_EN)

## Operation
- State register: RUN, MEMWAIT, ERR. Wait counter waitCnt, width $clog2(MEM_TIMEOUT+1).
- Outputs are combinational from state and current inputs (same-cycle stall). State and counters are registered.
- Load-use hazard (loadUse): resultSRCE_i & regWriteE_i & AD3E_i≠0 & (AD3E_i==rs1D_i | AD3E_i==rs2D_i).
- Memory stall (memStall): memReqM_i & !memReadyM_i.
- RUN, priority highest first:
  - memStall: all en=0, flushes=0; waitCnt←1; go to MEMWAIT.
  - branchTakenE_i: all en=1, flushD=flushE=1. A simultaneous loadUse is ignored, because the dependent instruction is squashed.
  - loadUse: enF=enD=0, enE=enM=1, flushE=1, flushD=0.
  - otherwise: all en=1, flushes=0.
- MEMWAIT:
  - memReadyM_i=1: outputs as RUN with memStall removed, i.e. branch and loadUse are evaluated this cycle. Go to RUN and clear waitCnt.
  - memReadyM_i=0 and waitCnt==MEM_TIMEOUT: all en=0; go to ERR.
  - otherwise: all en=0, flushes=0; waitCnt++.
- ERR: all en=0, flushes=0, memErr_o=1. The only exit is reset.
- A memReqM_i drop while in MEMWAIT is treated as ready and returns to RUN.

## Timing
- While rst_n=0: state=RUN, waitCnt=0, memErr_o=0, stallCycles_o=0. Outputs are forced to all en=0 and flushD=flushE=1 while reset is held.
- Reset asserted in any state, including MEMWAIT or ERR, returns to RUN immediately. The first normal cycle follows deassertion.
- Load-use stall costs exactly 1 cycle. Flush has 0 stall latency.
- ERR is entered at the edge ending the MEM_TIMEOUT+1-th consecutive not-ready cycle, counting the RUN cycle that detected the stall.
- memErr_o rises in the cycle after that edge and holds until reset.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stallCycles_o is present.
  - It is a 16-bit counter, incremented at each edge where enF_o=0 outside reset, and saturates at 0xFFFF.
- HAZARD_PERF_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 → en all 0, flushD=flushE=1, memErr_o=0. Release → next cycle all en=1, flushes=0.
- Load-use: AD3E_i=5, resultSRCE_i=1, regWriteE_i=1, rs2D_i=5 → one cycle with enF=enD=0, flushE=1. AD3E_i=0 with the same operands → no stall.
- Branch + load-use in the same cycle → enF..enM=1, flushD=flushE=1, no stall.
- MEM_TIMEOUT=4: memReqM_i=1, ready low 3 cycles then high → en=0 for 3 cycles, en=1 on the 4th cycle, memErr_o=0.
- MEM_TIMEOUT=4: ready held low → memErr_o=1 after 5 not-ready cycles, en stays 0. Asserting rst_n=0 mid-ERR clears memErr_o asynchronously.
- HAZARD_PERF_CNT_EN: 1 load-use stall + 3 memory wait cycles → stallCycles_o=4. Preload near 0xFFFF and keep stalling → output saturates at 0xFFFF.
